rb_slave: RTL and testbench

RB_SLAVE -- requirements
Module: rb_slave

---
 rtl/rb_slave.sv | 133 +++++++++++++
 tb/tb_rb_slave.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rb_slave.sv
// rb_slave: Avalon-MM responder backed by a DEPTH x BUSWIDTH buffer with WAITSTATES stall cycles.
// Compile option RB_SLAVE_ERRCNT_EN: reject and count accesses addressing beyond the buffer.
module rb_slave #(
    parameter int unsigned BUSWIDTH        = 512,
    parameter int unsigned BYTEENABLEWIDTH = 64,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned WAITSTATES      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [63:0]                AvalonAddr_i,
    input  logic                       AvalonRead_i,
    input  logic                       AvalonWrite_i,
    input  logic [BYTEENABLEWIDTH-1:0] AvalonByteEnable_i,
    input  logic [BUSWIDTH-1:0]        AvalonWriteData_i,
    output logic [BUSWIDTH-1:0]        AvalonReadData_o,
    output logic                       AvalonWaitReq_o,
    output logic [15:0]                ErrCnt_o
);

    localparam int unsigned LSB = $clog2(BYTEENABLEWIDTH);
    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned TOP = LSB + IW;
    localparam logic [3:0]  WAIT_INIT = 4'(WAITSTATES);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [BUSWIDTH-1:0]   mem [DEPTH];
    logic [IW-1:0]         idx;
    logic                  req;
    logic                  oor;
    logic                  in_ack;
    logic                  wr_commit;
    logic                  unused_addr;

    assign idx       = AvalonAddr_i[LSB +: IW];
    assign req       = AvalonRead_i | AvalonWrite_i;
    assign in_ack    = (state_q == StAck);
    assign wr_commit = in_ack && AvalonWrite_i && !oor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (WAITSTATES == 0) begin
                        state_d = StAck;
                    end else begin
                        state_d    = StWait;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
            StWait: begin
                // Master withdrew the request: drop it without ever reaching ACK.
                if (!req) begin
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign AvalonWaitReq_o = !in_ack;

    // A read with write also asserted is a write, so no data is returned.
    always_comb begin
        AvalonReadData_o = '0;
        if (in_ack && AvalonRead_i && !AvalonWrite_i && !oor) begin
            AvalonReadData_o = mem[idx];
        end
    end

    // Buffer has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < int'(BYTEENABLEWIDTH); b++) begin
                if (AvalonByteEnable_i[b]) begin
                    mem[idx][b*8 +: 8] <= AvalonWriteData_i[b*8 +: 8];
                end
            end
        end
    end

`ifdef RB_SLAVE_ERRCNT_EN
    logic [15:0] err_cnt_q;

    assign oor = |AvalonAddr_i[63:TOP];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 16'd0;
        end else if (in_ack && req && oor && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign ErrCnt_o    = err_cnt_q;
    assign unused_addr = ^AvalonAddr_i[LSB-1:0];
`else
    assign oor         = 1'b0;
    assign ErrCnt_o    = 16'd0;
    assign unused_addr = ^{AvalonAddr_i[63:TOP], AvalonAddr_i[LSB-1:0]};
`endif

endmodule

// File: tb/tb_rb_slave.sv
// Self-checking bench for rb_slave: a WAITSTATES=2 instance and a WAITSTATES=0 instance.
`timescale 1ns/1ps
module tb_rb_slave;

    localparam int unsigned BW   = 512;
    localparam int unsigned BE   = 64;
    localparam int          WS_A = 2;
    localparam int          WS_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0]   a_addr, b_addr;
    logic          a_rd, a_wr, b_rd, b_wr;
    logic [BE-1:0] a_be, b_be;
    logic [BW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic          a_wait, b_wait;
    logic [15:0]   a_err, b_err;

    rb_slave #(.BUSWIDTH(BW), .BYTEENABLEWIDTH(BE), .DEPTH(16), .WAITSTATES(WS_A)) dut_a (
        .clk(clk), .rst(rst),
        .AvalonAddr_i(a_addr), .AvalonRead_i(a_rd), .AvalonWrite_i(a_wr),
        .AvalonByteEnable_i(a_be), .AvalonWriteData_i(a_wdata),
        .AvalonReadData_o(a_rdata), .AvalonWaitReq_o(a_wait), .ErrCnt_o(a_err)
    );

    rb_slave #(.BUSWIDTH(BW), .BYTEENABLEWIDTH(BE), .DEPTH(16), .WAITSTATES(WS_B)) dut_b (
        .clk(clk), .rst(rst),
        .AvalonAddr_i(b_addr), .AvalonRead_i(b_rd), .AvalonWrite_i(b_wr),
        .AvalonByteEnable_i(b_be), .AvalonWriteData_i(b_wdata),
        .AvalonReadData_o(b_rdata), .AvalonWaitReq_o(b_wait), .ErrCnt_o(b_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [BW-1:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [BW-1:0] fill(input logic [7:0] b);
        return {BE{b}};
    endfunction

    task automatic drive(input bit sel, input bit rd, input bit wr, input logic [63:0] addr,
                         input logic [BW-1:0] wd, input logic [BE-1:0] be);
        if (sel) begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wd; b_be = be;
        end else begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wd; a_be = be;
        end
    endtask

    task automatic idle(input bit sel);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 64'h0, '0, '0);
    endtask

    // Issues one request, pushes the expected read data, and on ACK checks latency and data.
    task automatic xfer(input bit sel, input bit rd, input bit wr, input logic [63:0] addr,
                        input logic [BW-1:0] wd, input logic [BE-1:0] be,
                        input logic [BW-1:0] exp_rd, input string tag,
                        output int start_cyc, output int ack_cyc);
        int ack_at;
        logic [BW-1:0] exp;
        @(negedge clk);
        drive(sel, rd, wr, addr, wd, be);
        sb_q.push_back(exp_rd);
        start_cyc = cyc;
        ack_at = -1;
        for (int c = 0; c <= 20 && ack_at < 0; c++) begin
            if (c > 0) @(negedge clk);
            if (!(sel ? b_wait : a_wait)) ack_at = c;
        end
        ack_cyc = cyc;
        check_eq({tag, "_ack_cycle"}, BW'(ack_at), BW'((sel ? WS_B : WS_A) + 1));
        exp = sb_q.pop_front();
        if (ack_at >= 0) check_eq({tag, "_rdata"}, sel ? b_rdata : a_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] exp40;
        int s, k, base;
        int acks[3];

        drive(1'b0, 1'b0, 1'b0, 64'h0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 64'h0, '0, '0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_waitreq", BW'(a_wait), BW'(1));
        check_eq("rst_rdata", a_rdata, '0);
        check_eq("rst_errcnt", BW'(a_err), '0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_waitreq", BW'(a_wait), BW'(1));

        // Full-word write then read at 0x40
        xfer(1'b0, 1'b0, 1'b1, 64'h40, fill(8'hA5), '1, '0, "wr40", s, k);
        xfer(1'b0, 1'b1, 1'b0, 64'h40, '0, '0, fill(8'hA5), "rd40", s, k);

        // Single byte lane
        exp40 = fill(8'hA5);
        exp40[7:0] = 8'h3C;
        xfer(1'b0, 1'b0, 1'b1, 64'h40, fill(8'h3C), 64'h1, '0, "wr40_be0", s, k);
        xfer(1'b0, 1'b1, 1'b0, 64'h40, '0, '0, exp40, "rd40_be0", s, k);

        // Out-of-range address 0x400 against word 0
        xfer(1'b0, 1'b0, 1'b1, 64'h0, fill(8'h5A), '1, '0, "wr0", s, k);
        xfer(1'b0, 1'b0, 1'b1, 64'h400, fill(8'h77), '1, '0, "wr400", s, k);
`ifdef RB_SLAVE_ERRCNT_EN
        xfer(1'b0, 1'b1, 1'b0, 64'h400, '0, '0, '0, "rd400", s, k);
        idle(1'b0);
        check_eq("errcnt_oor", BW'(a_err), BW'(2));
        xfer(1'b0, 1'b1, 1'b0, 64'h0, '0, '0, fill(8'h5A), "rd0", s, k);
`else
        xfer(1'b0, 1'b1, 1'b0, 64'h400, '0, '0, fill(8'h77), "rd400", s, k);
        idle(1'b0);
        check_eq("errcnt_oor", BW'(a_err), '0);
        xfer(1'b0, 1'b1, 1'b0, 64'h0, '0, '0, fill(8'h77), "rd0", s, k);
`endif

        // Read and write together: write wins, no read data
        xfer(1'b0, 1'b1, 1'b1, 64'h80, fill(8'h11), '1, '0, "rw80", s, k);
        xfer(1'b0, 1'b1, 1'b0, 64'h85, '0, '0, fill(8'h11), "rd85", s, k);

        // Write withdrawn during WAIT must not commit
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 64'h40, fill(8'hEE), '1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 64'h0, '0, '0);
        repeat (3) @(negedge clk);
        check_eq("abort_waitreq", BW'(a_wait), BW'(1));
        xfer(1'b0, 1'b1, 1'b0, 64'h40, '0, '0, exp40, "rd40_abort", s, k);

        // Reset pulsed during WAIT of a write to 0xC0
        xfer(1'b0, 1'b0, 1'b1, 64'hC0, fill(8'h22), '1, '0, "wrC0", s, k);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 64'hC0, fill(8'h33), '1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_waitreq", BW'(a_wait), BW'(1));
        check_eq("midrst_rdata", a_rdata, '0);
        check_eq("midrst_errcnt", BW'(a_err), '0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 64'h0, '0, '0);
        rst = 1'b0;
        xfer(1'b0, 1'b1, 1'b0, 64'hC0, '0, '0, fill(8'h22), "rdC0", s, k);
        idle(1'b0);

        // Zero wait states, back-to-back reads
        xfer(1'b1, 1'b0, 1'b1, 64'h0, fill(8'hC3), '1, '0, "b_wr0", s, k);
        base = 0;
        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, 1'b1, 1'b0, 64'h0, '0, '0, fill(8'hC3), $sformatf("b_rd%0d", i), s, k);
            if (i == 0) base = s;
            acks[i] = k;
        end
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("b2b_ack%0d", i), BW'(acks[i] - base), BW'(2 * i + 1));
        end
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
